// File: rtl/countdown_pkg.sv
// Shared types for the game countdown timer: FSM state encoding and the
// debug bundle exposed by the top level.
package countdown_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Internal visibility: current FSM state and the unit-counter wrap pulse.
    typedef struct packed {
        state_t state;
        logic   unit_tick;
    } dbg_t;

    // Value written into time_left on load: zero selects the default.
    function automatic logic [31:0] load_value(input logic [31:0] val,
                                               input logic [31:0] dflt);
        return (val == 32'd0) ? dflt : val;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Modulo-DIV event counter. Counts enabled cycles 0..DIV-1; the cycle after
// the enabled edge where the count was DIV-1 it wraps to 0 and pulses tick.
// 'last' flags that the next enabled edge is the wrapping one, so a parent
// can act on the same edge the wrap happens.
module rate_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic last
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign last = (cnt == LAST_CNT);

    // Count enabled cycles, wrap at DIV-1 and emit a registered tick; clr
    // restarts the count without producing a tick.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (last) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + CW'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Game-level countdown: clk is divided into frame ticks, frame ticks into
// time units, and each completed unit decrements time_left while running.
// expired pulses for one cycle on the cycle time_left first reads zero.
//
// Control inputs are level-sampled on every posedge; priority is
// rst > load > pause > start. There is no handshake: load/start/pause act
// on each edge they are high, and repeated assertion is harmless.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int CLK_DIV        = 833333,
    parameter int TICKS_PER_UNIT = 60,
    parameter int TIME_WIDTH     = 8,
    parameter int DEFAULT_TIME   = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [TIME_WIDTH-1:0] load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [TIME_WIDTH-1:0] time_left,
    output logic                  running,
    output logic                  frame_tick,
    output logic                  expired,
    output dbg_t                  dbg
);

    localparam logic [TIME_WIDTH-1:0] DEFAULT_VAL = TIME_WIDTH'(DEFAULT_TIME);

    state_t                state, state_n;
    logic [TIME_WIDTH-1:0] time_n;
    logic                  running_n;
    logic                  expired_n;

    logic                  frame_en;
    logic                  frame_last;
    logic                  unit_tick;
    logic                  unit_last;
    logic                  dec;
    logic [31:0]           load_word;

    // The divider only advances on RUN cycles that are not being left via
    // pause or load, so the cycle that samples pause adds no progress.
    assign frame_en = (state == ST_RUN) && !pause && !load;

    // A unit completes on the edge the frame divider wraps while the unit
    // counter already holds its last value; decrementing on that same edge
    // keeps time_left, expired and the causing frame_tick aligned.
    assign dec = frame_en && frame_last && unit_last;

    assign load_word = load_value(32'(load_val), 32'(DEFAULT_VAL));

    rate_divider #(
        .DIV (CLK_DIV)
    ) u_frame_div (
        .clk  (clk),
        .rst  (rst),
        .en   (frame_en),
        .clr  (load),
        .tick (frame_tick),
        .last (frame_last)
    );

    rate_divider #(
        .DIV (TICKS_PER_UNIT)
    ) u_unit_div (
        .clk  (clk),
        .rst  (rst),
        .en   (frame_tick),
        .clr  (load),
        .tick (unit_tick),
        .last (unit_last)
    );

    // Next-state, next time_left and registered output values.
    always_comb begin
        state_n   = state;
        time_n    = time_left;
        expired_n = 1'b0;

        if (load) begin
            state_n = ST_IDLE;
            time_n  = load_word[TIME_WIDTH-1:0];
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!pause && start && (time_left != '0)) begin
                        state_n = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_n = ST_PAUSE;
                    end else if (dec && (time_left != '0)) begin
                        time_n = time_left - TIME_WIDTH'(1);
                        if (time_left == TIME_WIDTH'(1)) begin
                            state_n   = ST_EXPIRED;
                            expired_n = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause && start) begin
                        state_n = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    state_n = ST_EXPIRED;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        running_n = (state_n == ST_RUN);
    end

    // State, time_left and the registered running/expired outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            time_left <= DEFAULT_VAL;
            running   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_n;
            time_left <= time_n;
            running   <= running_n;
            expired   <= expired_n;
        end
    end

    assign dbg.state     = state;
    assign dbg.unit_tick = unit_tick;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a small configuration
// (CLK_DIV=4, TICKS_PER_UNIT=3, DEFAULT_TIME=2).
module tb_countdown_timer;
    import countdown_pkg::*;

    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [TW-1:0] load_val = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [TW-1:0] time_left;
    logic          running;
    logic          frame_tick;
    logic          expired;
    dbg_t          dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    countdown_timer #(
        .CLK_DIV        (4),
        .TICKS_PER_UNIT (3),
        .TIME_WIDTH     (TW),
        .DEFAULT_TIME   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .time_left  (time_left),
        .running    (running),
        .frame_tick (frame_tick),
        .expired    (expired),
        .dbg        (dbg)
    );

    // clock
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 ns later, inputs changed there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [TW-1:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0; load_val = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++; if (time_left !== 8'd2) begin tests_failed++; $display("FAIL reset_time_left got %0d exp 2", time_left); end
        tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL reset_running got %b exp 0", running); end
        tests_run++; if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_tick got %b exp 0", frame_tick); end
        tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL reset_expired got %b exp 0", expired); end
        tests_run++; if (dbg.state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state got %0d exp %0d", dbg.state, ST_IDLE); end
    endtask

    task automatic test_countdown();
        logic [TW-1:0] exp_tl;
        do_load(8'd3);
        tests_run++; if (time_left !== 8'd3) begin tests_failed++; $display("FAIL cd_load got %0d exp 3", time_left); end
        tests_run++; if (dbg.state !== ST_IDLE) begin tests_failed++; $display("FAIL cd_load_state got %0d exp %0d", dbg.state, ST_IDLE); end
        do_start();
        tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL cd_running got %b exp 1", running); end
        for (int k = 1; k <= 36; k++) begin
            step();
            exp_tl = 8'(3 - (k / 12));
            tests_run++; if (time_left !== exp_tl) begin tests_failed++; $display("FAIL cd_time_left k=%0d got %0d exp %0d", k, time_left, exp_tl); end
            tests_run++; if (frame_tick !== (k % 4 == 0)) begin tests_failed++; $display("FAIL cd_frame_tick k=%0d got %b exp %b", k, frame_tick, (k % 4 == 0)); end
            tests_run++; if (expired !== (k == 36)) begin tests_failed++; $display("FAIL cd_expired k=%0d got %b exp %b", k, expired, (k == 36)); end
            tests_run++; if (running !== (k < 36)) begin tests_failed++; $display("FAIL cd_running k=%0d got %b exp %b", k, running, (k < 36)); end
            tests_run++; if (dbg.unit_tick !== (k == 13 || k == 25)) begin tests_failed++; $display("FAIL cd_unit_tick k=%0d got %b exp %b", k, dbg.unit_tick, (k == 13 || k == 25)); end
        end
        step();
        tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL cd_expired_once got %b exp 0", expired); end
        tests_run++; if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL cd_tick_after got %b exp 0", frame_tick); end
        tests_run++; if (dbg.state !== ST_EXPIRED) begin tests_failed++; $display("FAIL cd_state got %0d exp %0d", dbg.state, ST_EXPIRED); end
        // start in EXPIRED is ignored
        do_start();
        step();
        tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL cd_exp_start_running got %b exp 0", running); end
        tests_run++; if (time_left !== 8'd0) begin tests_failed++; $display("FAIL cd_exp_hold got %0d exp 0", time_left); end
        tests_run++; if (dbg.state !== ST_EXPIRED) begin tests_failed++; $display("FAIL cd_exp_state got %0d exp %0d", dbg.state, ST_EXPIRED); end
    endtask

    task automatic test_pause();
        do_load(8'd3);
        tests_run++; if (dbg.state !== ST_IDLE) begin tests_failed++; $display("FAIL pz_load_state got %0d exp %0d", dbg.state, ST_IDLE); end
        do_start();
        for (int k = 1; k <= 5; k++) step();
        pause = 1'b1;
        for (int k = 6; k <= 15; k++) begin
            step();
            tests_run++; if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL pz_frame_tick k=%0d got %b exp 0", k, frame_tick); end
            tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL pz_running k=%0d got %b exp 0", k, running); end
            tests_run++; if (time_left !== 8'd3) begin tests_failed++; $display("FAIL pz_time_left k=%0d got %0d exp 3", k, time_left); end
        end
        tests_run++; if (dbg.state !== ST_PAUSE) begin tests_failed++; $display("FAIL pz_state got %0d exp %0d", dbg.state, ST_PAUSE); end
        pause = 1'b0;
        do_start();
        tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL pz_resume got %b exp 1", running); end
        for (int k = 17; k <= 23; k++) begin
            step();
            tests_run++; if (time_left !== ((k == 23) ? 8'd2 : 8'd3)) begin tests_failed++; $display("FAIL pz_dec k=%0d got %0d exp %0d", k, time_left, (k == 23) ? 2 : 3); end
            tests_run++; if (frame_tick !== (k == 19 || k == 23)) begin tests_failed++; $display("FAIL pz_tick k=%0d got %b exp %b", k, frame_tick, (k == 19 || k == 23)); end
        end
    endtask

    task automatic test_load_during_run();
        // still running from the previous test with time_left=2
        for (int k = 0; k < 5; k++) step();
        do_load(8'd5);
        tests_run++; if (time_left !== 8'd5) begin tests_failed++; $display("FAIL ld_time_left got %0d exp 5", time_left); end
        tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL ld_running got %b exp 0", running); end
        tests_run++; if (dbg.state !== ST_IDLE) begin tests_failed++; $display("FAIL ld_state got %0d exp %0d", dbg.state, ST_IDLE); end
        for (int k = 0; k < 6; k++) begin
            step();
            tests_run++; if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL ld_idle_tick k=%0d got %b exp 0", k, frame_tick); end
        end
        do_start();
        for (int k = 1; k <= 12; k++) begin
            step();
            tests_run++; if (time_left !== ((k == 12) ? 8'd4 : 8'd5)) begin tests_failed++; $display("FAIL ld_dec k=%0d got %0d exp %0d", k, time_left, (k == 12) ? 4 : 5); end
            tests_run++; if (frame_tick !== (k % 4 == 0)) begin tests_failed++; $display("FAIL ld_tick k=%0d got %b exp %b", k, frame_tick, (k % 4 == 0)); end
        end
    endtask

    task automatic test_load_zero();
        do_load(8'd0);
        tests_run++; if (time_left !== 8'd2) begin tests_failed++; $display("FAIL lz_default got %0d exp 2", time_left); end
        start = 1'b1; pause = 1'b1;
        step();
        start = 1'b0; pause = 1'b0;
        tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL lz_sp_running got %b exp 0", running); end
        tests_run++; if (dbg.state !== ST_IDLE) begin tests_failed++; $display("FAIL lz_sp_state got %0d exp %0d", dbg.state, ST_IDLE); end
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++; if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL lz_idle_tick k=%0d got %b exp 0", k, frame_tick); end
        end
        do_start();
        start = 1'b1; pause = 1'b1;
        step();
        start = 1'b0; pause = 1'b0;
        tests_run++; if (dbg.state !== ST_PAUSE) begin tests_failed++; $display("FAIL lz_run_sp_state got %0d exp %0d", dbg.state, ST_PAUSE); end
        tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL lz_run_sp_running got %b exp 0", running); end
    endtask

    task automatic test_single_unit();
        do_load(8'd1);
        do_start();
        for (int k = 1; k <= 12; k++) begin
            step();
            tests_run++; if (time_left !== ((k == 12) ? 8'd0 : 8'd1)) begin tests_failed++; $display("FAIL su_time_left k=%0d got %0d exp %0d", k, time_left, (k == 12) ? 0 : 1); end
            tests_run++; if (expired !== (k == 12)) begin tests_failed++; $display("FAIL su_expired k=%0d got %b exp %b", k, expired, (k == 12)); end
        end
        do_load(8'd1);
        tests_run++; if (dbg.state !== ST_IDLE) begin tests_failed++; $display("FAIL su_reload_state got %0d exp %0d", dbg.state, ST_IDLE); end
        tests_run++; if (time_left !== 8'd1) begin tests_failed++; $display("FAIL su_reload got %0d exp 1", time_left); end
    endtask

    task automatic test_reset_mid_run();
        do_start();
        for (int k = 1; k <= 3; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++; if (time_left !== 8'd2) begin tests_failed++; $display("FAIL rm_time_left got %0d exp 2", time_left); end
        tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL rm_running got %b exp 0", running); end
        tests_run++; if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL rm_frame_tick got %b exp 0", frame_tick); end
        tests_run++; if (expired !== 1'b0) begin tests_failed++; $display("FAIL rm_expired got %b exp 0", expired); end
        tests_run++; if (dbg.state !== ST_IDLE) begin tests_failed++; $display("FAIL rm_state got %0d exp %0d", dbg.state, ST_IDLE); end
        for (int k = 0; k < 15; k++) begin
            step();
            tests_run++; if (expired !== 1'b0 || time_left !== 8'd2) begin tests_failed++; $display("FAIL rm_quiet k=%0d got exp=%b tl=%0d exp 0/2", k, expired, time_left); end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_load_during_run();
        test_load_zero();
        test_single_unit();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
